alu_bit_serial_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/bitSlice.sv | 37 +++
 rtl/alu_bit_serial_seq.sv | 153 +++++++++++++++
 tb/tb_alu_bit_serial_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: 3-bit op encoding, sequencer state type and op helpers.
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_PASS_B = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD    = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB    = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND    = 3'b100;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR     = 3'b101;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR    = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Add/sub are the only ops that produce meaningful carry/overflow.
    function automatic logic op_is_arith(input logic [ALU_CTRL_W-1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

    // 001 and 111 are unassigned encodings; their result is forced to zero.
    function automatic logic op_is_legal(input logic [ALU_CTRL_W-1:0] op);
        return (op != 3'b001) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/bitSlice.sv
// One-bit ALU slice: full adder with B inversion for subtract, plus bitwise ops.
module bitSlice
    import alu_pkg::*;
(
    input  logic                  Ai,
    input  logic                  Bi,
    input  logic                  cin,
    input  logic [ALU_CTRL_W-1:0] s,
    output logic                  f,
    output logic                  cout
);

    logic b_eff;
    logic sum;

    // Adder path; subtract inverts B and relies on the caller's carry-in of 1.
    always_comb begin
        b_eff = (s == ALU_SUB) ? ~Bi : Bi;
        sum   = Ai ^ b_eff ^ cin;
        cout  = (Ai & b_eff) | (cin & (Ai ^ b_eff));
    end

    // Function select.
    always_comb begin
        f = 1'b0;
        case (s)
            ALU_PASS_B: f = Bi;
            ALU_ADD:    f = sum;
            ALU_SUB:    f = sum;
            ALU_AND:    f = Ai & Bi;
            ALU_OR:     f = Ai | Bi;
            ALU_XOR:    f = Ai ^ Bi;
            default:    f = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_bit_serial_seq.sv
// Bit-serial ALU sequencer: one bit per clock through a single bitSlice, LSB first,
// with registered result and NZCV flags updated only on completion.
module alu_bit_serial_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic [ALU_CTRL_W-1:0] cntrl,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic                  negative,
    output logic                  zero,
    output logic                  overflow,
    output logic                  carry_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t                state_q;
    state_t                state_d;

    logic [WIDTH-1:0]      a_sh;
    logic [WIDTH-1:0]      b_sh;
    logic [WIDTH-1:0]      res_sh;
    logic [WIDTH-1:0]      res_fin;
    logic [ALU_CTRL_W-1:0] cntrl_q;
    logic                  carry_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  slice_f;
    logic                  slice_cout;
    logic                  bit_in;
    logic                  last_bit;

    logic                  load_op;
    logic                  step;
    logic                  finish;

    bitSlice u_slice (
        .Ai   (a_sh[0]),
        .Bi   (b_sh[0]),
        .cin  (carry_q),
        .s    (cntrl_q),
        .f    (slice_f),
        .cout (slice_cout)
    );

    // Slice bit as stored, with illegal ops gated to zero; full result if this is the last bit.
    always_comb begin
        bit_in   = op_is_legal(cntrl_q) ? slice_f : 1'b0;
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
        res_fin  = {bit_in, res_sh[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE, so a start during RUN is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = RUN;
            RUN:     if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state control strobes for the datapath and output registers.
    always_comb begin
        load_op = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: load_op = start;
            RUN: begin
                step   = 1'b1;
                finish = last_bit;
            end
            default: ;
        endcase
    end

    // Operand shifters, op register, carry flip-flop and bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            cntrl_q <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load_op) begin
            a_sh    <= A;
            b_sh    <= B;
            res_sh  <= '0;
            cntrl_q <= cntrl;
            carry_q <= cntrl[0];
            cnt_q   <= '0;
        end else if (step) begin
            a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
            res_sh  <= res_fin;
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Status, result and flag registers; result/flags move only on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_op) begin
                busy <= 1'b1;
            end
            if (finish) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                result   <= res_fin;
                negative <= res_fin[WIDTH-1];
                zero     <= (res_fin == '0);
                if (op_is_arith(cntrl_q)) begin
                    carry_out <= slice_cout;
                    overflow  <= carry_q ^ slice_cout;
                end else begin
                    carry_out <= 1'b0;
                    overflow  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Directed bench for alu_bit_serial_seq at WIDTH=64 and WIDTH=8.
module tb_alu_bit_serial_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    logic        start;
    logic [63:0] A, B, result;
    logic [2:0]  cntrl;
    logic        busy, done, negative, zero, overflow, carry_out;

    logic        start8;
    logic [7:0]  a8, b8, result8;
    logic [2:0]  cntrl8;
    logic        busy8, done8, n8, z8, v8, c8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_bit_serial_seq #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .cntrl(cntrl),
        .busy(busy), .done(done), .result(result), .negative(negative),
        .zero(zero), .overflow(overflow), .carry_out(carry_out)
    );

    alu_bit_serial_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .cntrl(cntrl8),
        .busy(busy8), .done(done8), .result(result8), .negative(n8),
        .zero(z8), .overflow(v8), .carry_out(c8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op on the 64-bit unit and count negedges from E0 until done.
    task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         output int lat);
        @(negedge clk);
        A = a; B = b; cntrl = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = ~a; B = ~b; cntrl = ALU_XOR;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op64(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] er, input logic [3:0] ef);
        int lat;
        run64(op, a, b, lat);
        check({tag, ".lat"}, 64'(lat), 64'd64);
        check({tag, ".res"}, result, er);
        check({tag, ".nzcv"}, 64'({negative, zero, carry_out, overflow}), 64'(ef));
    endtask

    task automatic op8(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        a8 = a; b8 = b; cntrl8 = op; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~a; b8 = ~b;
        lat = 0;
        while (done8 !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'd8);
        check({tag, ".res"}, 64'(result8), 64'(er));
        check({tag, ".nzcv"}, 64'({n8, z8, c8, v8}), 64'(ef));
    endtask

    initial begin
        int lat;
        int seen;
        logic [63:0] pa, pb;

        reset = 1'b1;
        start = 1'b0; A = '0; B = '0; cntrl = '0;
        start8 = 1'b0; a8 = '0; b8 = '0; cntrl8 = '0;
        pa = 64'hF0F0_F0F0_F0F0_F0F0;
        pb = 64'hFF00_FF00_FF00_FF00;

        repeat (2) @(negedge clk);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.res", result, 64'd0);
        check("rst.nzcv", 64'({negative, zero, carry_out, overflow}), 64'd0);
        reset = 1'b0;

        // Arithmetic, NZCV order = {N,Z,C,V}
        op64("add5_3", ALU_ADD, 64'd5, 64'd3, 64'd8, 4'b0000);
        op64("sub3_5", ALU_SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
        op64("sub5_5", ALU_SUB, 64'd5, 64'd5, 64'd0, 4'b0110);
        op64("add_ovf", ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001);
        op64("add_cry", ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFE, 4'b1010);

        // Logic ops and illegal encodings
        op64("and", ALU_AND, pa, pb, 64'hF000_F000_F000_F000, 4'b1000);
        op64("or", ALU_OR, pa, pb, 64'hFFF0_FFF0_FFF0_FFF0, 4'b1000);
        op64("xor", ALU_XOR, pa, pb, 64'h0FF0_0FF0_0FF0_0FF0, 4'b0000);
        op64("passb", ALU_PASS_B, pa, pb, 64'hFF00_FF00_FF00_FF00, 4'b1000);
        op64("ill111", 3'b111, pa, pb, 64'd0, 4'b0100);
        op64("ill001", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, pb, 64'd0, 4'b0100);

        // Load a nonzero result, then start mid-run must be ignored
        op64("pre", ALU_PASS_B, 64'd0, 64'd42, 64'd42, 4'b0000);
        @(negedge clk);
        A = 64'd100; B = 64'd23; cntrl = ALU_ADD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (10) begin @(negedge clk); lat++; end
        A = 64'd999; B = 64'd1; cntrl = ALU_SUB; start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        check("mid.busy", 64'(busy), 64'd1);
        check("mid.hold", result, 64'd42);
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("mid.lat", 64'(lat), 64'd64);
        check("mid.res", result, 64'd123);

        // Start in the done cycle is accepted
        A = 64'd7; B = 64'd2; cntrl = ALU_SUB; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b.busy", 64'(busy), 64'd1);
        check("b2b.done", 64'(done), 64'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("b2b.lat", 64'(lat), 64'd64);
        check("b2b.res", result, 64'd5);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        A = 64'd1; B = 64'd1; cntrl = ALU_ADD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst.busy", 64'(busy), 64'd0);
        check("arst.done", 64'(done), 64'd0);
        check("arst.res", result, 64'd0);
        check("arst.nzcv", 64'({negative, zero, carry_out, overflow}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("arst.quiet", 64'(seen), 64'd0);
        op64("post_rst", ALU_ADD, 64'd5, 64'd3, 64'd8, 4'b0000);

        // Arithmetic at WIDTH=8
        op8("w8.add5_3", ALU_ADD, 8'd5, 8'd3, 8'd8, 4'b0000);
        op8("w8.sub3_5", ALU_SUB, 8'd3, 8'd5, 8'hFE, 4'b1000);
        op8("w8.sub5_5", ALU_SUB, 8'd5, 8'd5, 8'h00, 4'b0110);
        op8("w8.add_ovf", ALU_ADD, 8'h7F, 8'h01, 8'h80, 4'b1001);
        op8("w8.add_cry", ALU_ADD, 8'hFF, 8'hFF, 8'hFE, 4'b1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
